bus_capture_reader: RTL
=======================

# bus_capture_reader

Receiving end of the board's registered tri-state byte bus: where a '534-style driver places a byte on the shared bus, this block samples it. It synchronises the master's asynchronous strobe, captures the bus byte into a small FIFO, and answers with an acknowledge. It stalls the acknowledge (wait state) while the FIFO is full. A valid/ready port hands bytes to local logic.

## Interface
- DEPTH, 4: FIFO entries; power of two, ≥2
- WIDTH, 8: bus/data width
- CK  in  1  system clock, all state on rising edge
- RESET  in  1  synchronous, active-high reset
- BUS  in  WIDTH  shared data bus as seen at the receiver (resolved tri-state net)
- BUS_P  in  1  bus parity bit, odd parity over BUS (present only with BUS_PARITY_EN)
- STB_n  in  1  asynchronous strobe from bus master, active low
- ACK_n  out  1  acknowledge to master, active low, registered
- DOUT  out  WIDTH  FIFO head byte
- VALID  out  1  DOUT holds an unread byte
- READY  in  1  consumer accepts DOUT this cycle
- COUNT  out  log2(DEPTH)+1  bytes held
- PERR  out  1  sticky parity error flag
- CLR_ERR  in  1  clears PERR

## Operation
- STB_n passes two flops (s1, s2); both reset to 1. All decisions use s2 only.
- FSM states:
  - IDLE: s2==0 and FIFO not full → push BUS, ACK_n←0, go ACK. s2==0 and full → go WAIT_SPACE.
  - WAIT_SPACE: not full (as registered at this edge) → push BUS, ACK_n←0, go ACK. s2==1 (master abandoned) → IDLE, nothing pushed.
  - ACK: hold ACK_n low until s2==1, then ACK_n←1 and go IDLE.
- Entry into IDLE is level-sensitive. One strobe yields exactly one push, because ACK waits for release.
- FIFO: circular, DEPTH entries, read/write pointers of log2(DEPTH) bits wrapping modulo DEPTH.
  - COUNT = 0..DEPTH. VALID = (COUNT != 0). DOUT = mem[rd_ptr].
  - Pop on VALID&&READY. READY while empty is ignored.
- Simultaneous push and pop: COUNT unchanged, both pointers advance.
- Full: push is decided on the full flag before the same-edge pop. A byte popped at edge N frees space for a push at edge N+1, not at N.
- Reset values: ACK_n=1, VALID=0, COUNT=0, PERR=0, state IDLE, pointers 0. DOUT content is don't-care while VALID=0.
- Reset mid-handshake drops the transfer and flushes the FIFO. If STB_n is still low after reset, it is taken as a new transfer (push about 2 cycles after RESET falls).

## Timing
- STB_n first sampled low at edge t: s2 low after edge t+1. Push and ACK_n fall at edge t+2 (FIFO not full).
- BUS is sampled directly at the push edge. The master holds BUS stable from STB_n fall until ACK_n is observed low.
- VALID rises after the push edge when the FIFO was empty. DOUT is valid the same cycle.
- STB_n released, first sampled high at edge u: ACK_n rises at edge u+2.
- Strobe-to-ack latency: 2–3 CK nominal, plus one cycle per stalled full cycle in WAIT_SPACE.
- Pop-to-VALID update: next edge.

## Configuration
- BUS_PARITY_EN defined:
  - BUS_P port exists.
  - At each push, if ^{BUS,BUS_P}==0 (even), PERR←1. The byte is still stored and acked.
  - PERR is sticky. It is cleared by CLR_ERR or RESET. A push with a parity error in the same cycle as CLR_ERR leaves PERR=1.
- BUS_PARITY_EN undefined: no BUS_P port, PERR constant 0, CLR_ERR ignored.

## Test plan
- Single transfer: BUS=8'hA5, STB_n low at cycle 10, READY=0.
  - Push, ACK_n=0, VALID=1, DOUT=A5 and COUNT=1 at cycle 12.
  - Release STB_n at cycle 20 → ACK_n=1 at cycle 22.
- Fill and stall (DEPTH=4, READY=0): strobes carrying 01,02,03,04 → COUNT=4.
  - Fifth strobe with 05: ACK_n stays 1, FSM in WAIT_SPACE.
  - READY=1 for one cycle: pops 01, 05 pushes the following cycle, ACK_n falls, COUNT=4, DOUT=02.
- Streaming with READY=1 throughout: 16 strobes with bytes 00..0F.
  - All bytes are read out in order and pointers wrap.
  - COUNT never exceeds 1; simultaneous push/pop leaves COUNT unchanged.
- Abandoned strobe: FIFO full, STB_n low 5 cycles then high → no push, ACK_n never 0, FSM back in IDLE, COUNT=4.
- Reset mid-ACK: RESET pulsed while ACK_n=0 and COUNT=2 → next cycle ACK_n=1, VALID=0, COUNT=0. With STB_n still low, one new push occurs.
- Parity (BUS_PARITY_EN): BUS=8'h03, BUS_P=0 → byte stored, PERR=1. Then CLR_ERR=1 → PERR=0; BUS=8'h03, BUS_P=1 → PERR stays 0.

Source files
------------

// File: rtl/bus_capture_reader_if.sv
// Byte-bus handshake bundle between a bus master and bus_capture_reader.
// BUS_P exists only when BUS_PARITY_EN is defined.
interface bus_capture_reader_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] BUS;
`ifdef BUS_PARITY_EN
  logic             BUS_P;
`endif
  logic             STB_n;
  logic             ACK_n;

`ifdef BUS_PARITY_EN
  modport master (output BUS, output BUS_P, output STB_n, input ACK_n);
  modport slave  (input BUS, input BUS_P, input STB_n, output ACK_n);
`else
  modport master (output BUS, output STB_n, input ACK_n);
  modport slave  (input BUS, input STB_n, output ACK_n);
`endif
endinterface

// File: rtl/bus_capture_reader.sv
// Receiver for the registered tri-state byte bus: synchronises the master's
// strobe, captures BUS into a circular FIFO and acknowledges, inserting wait
// states while the FIFO is full. Bytes leave through a valid/ready port.
// Optional feature macro: BUS_PARITY_EN (odd parity check on BUS/BUS_P, sticky PERR).
module bus_capture_reader #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                     CK,
  input  logic                     RESET,
  bus_capture_reader_if.slave      bus_if,
  output logic [WIDTH-1:0]         DOUT,
  output logic                     VALID,
  input  logic                     READY,
  output logic [$clog2(DEPTH):0]   COUNT,
  output logic                     PERR,
  input  logic                     CLR_ERR
);
  localparam int          AW         = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = DEPTH[AW:0];

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT_SPACE,
    ST_ACK
  } state_t;

  state_t           state;
  logic             s1;
  logic             s2;
  logic             ack_n;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             full;
  logic             push;
  logic             pop;

  // Push/pop decisions; push uses the registered full flag, so a same-edge pop cannot free space.
  always_comb begin
    full = (count == FULL_COUNT);
    // An abandoned strobe (s2 high) never pushes, even if space has just appeared.
    push = !s2 && !full && (state != ST_ACK);
    pop  = (count != '0) && READY;
  end

  // Two-flop synchroniser for the asynchronous strobe; idles high.
  always_ff @(posedge CK) begin
    if (RESET) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
    end else begin
      s1 <= bus_if.STB_n;
      s2 <= s1;
    end
  end

  // Handshake FSM with registered acknowledge.
  always_ff @(posedge CK) begin
    if (RESET) begin
      state <= ST_IDLE;
      ack_n <= 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          if (!s2) begin
            if (!full) begin
              ack_n <= 1'b0;
              state <= ST_ACK;
            end else begin
              state <= ST_WAIT_SPACE;
            end
          end
        end
        ST_WAIT_SPACE: begin
          if (s2) begin
            state <= ST_IDLE;
          end else if (!full) begin
            ack_n <= 1'b0;
            state <= ST_ACK;
          end
        end
        ST_ACK: begin
          if (s2) begin
            ack_n <= 1'b1;
            state <= ST_IDLE;
          end
        end
        default: begin
          ack_n <= 1'b1;
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // FIFO storage; contents need no reset since VALID gates them.
  always_ff @(posedge CK) begin
    if (push) begin
      mem[wr_ptr] <= bus_if.BUS;
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge CK) begin
    if (RESET) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push && !pop) begin
        count <= count + 1'b1;
      end else if (pop && !push) begin
        count <= count - 1'b1;
      end
    end
  end

  assign bus_if.ACK_n = ack_n;
  assign DOUT         = mem[rd_ptr];
  assign VALID        = (count != '0);
  assign COUNT        = count;

`ifdef BUS_PARITY_EN
  logic perr;

  // Sticky parity error; a bad push wins over a same-cycle clear.
  always_ff @(posedge CK) begin
    if (RESET) begin
      perr <= 1'b0;
    end else if (push && !(^{bus_if.BUS, bus_if.BUS_P})) begin
      perr <= 1'b1;
    end else if (CLR_ERR) begin
      perr <= 1'b0;
    end
  end

  assign PERR = perr;
`else
  logic unused_clr_err;

  assign unused_clr_err = CLR_ERR;
  assign PERR           = 1'b0;
`endif
endmodule
